// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
//
// Two-requester arbiter and sequencer for the 64-word data RAM / memory-mapped
// I/O bus. Port 0 is the CPU load/store path and port 1 is the debug/loader
// path. One access is in flight at a time. A write occupies IDLE->ACCESS.
// A read occupies IDLE->ACCESS->RESP and returns registered data one cycle
// after RESP. Address decode (RAM 0-63, IO64 out, IO65 in, others read 0)
// lives in the memory block. Addresses pass through unchanged.
//
// Build option:
//   RAM_ARB_FIXED_PRIO_EN  defined   -> fixed priority, port 0 wins every tie
//                          undefined -> round-robin on ties (default)
//
// Ports:
//   CLK, RESET                  clock (rising edge), synchronous active-high reset
//   REQx, WEx, ADDRx, WDATAx    requester x: request, write/read, address, data
//   GNTx                        one-cycle grant pulse in the ACCESS cycle
//   RVALIDx                     one-cycle read-data-valid pulse
//   RDATA                       registered read data shared by both ports
//   BUSY                        high whenever the sequencer is not IDLE
//   RAM_ADDR, RAM_IN            address and write data to the memory
//   RAM_WEN, RAM_EX             write enable and CLK_EX write-phase strobe
//   RAM_OUT                     read data from the memory
// -----------------------------------------------------------------------------
module ram_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          REQ0,
  input  logic          WE0,
  input  logic [AW-1:0] ADDR0,
  input  logic [DW-1:0] WDATA0,
  output logic          GNT0,
  output logic          RVALID0,
  input  logic          REQ1,
  input  logic          WE1,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA1,
  output logic          GNT1,
  output logic          RVALID1,
  output logic [DW-1:0] RDATA,
  output logic          BUSY,
  output logic [AW-1:0] RAM_ADDR,
  output logic [DW-1:0] RAM_IN,
  output logic          RAM_WEN,
  output logic          RAM_EX,
  input  logic [DW-1:0] RAM_OUT
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          port_q, port_d;     // port that owns the access in flight
  logic          we_q, we_d;         // access in flight is a write
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic          pick1;              // arbitration result: 1 selects port 1
  logic          in_access;

`ifdef RAM_ARB_FIXED_PRIO_EN
  // Port 1 is served only when port 0 is not asking.
  assign pick1 = ~REQ0;
`else
  logic last_q, last_d;              // port granted most recently

  // On a tie the port that did not go last wins; otherwise the lone requester.
  assign pick1 = (REQ0 && REQ1) ? ~last_q : REQ1;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    port_d    = port_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
    last_d    = last_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (REQ0 || REQ1) begin
          port_d  = pick1;
          we_d    = pick1 ? WE1    : WE0;
          addr_d  = pick1 ? ADDR1  : ADDR0;
          wdata_d = pick1 ? WDATA1 : WDATA0;
`ifndef RAM_ARB_FIXED_PRIO_EN
          last_d  = pick1;
`endif
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_d = we_q ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        // Memory data for the address presented in ACCESS is valid now.
        rdata_d   = RAM_OUT;
        rvalid0_d = ~port_q;
        rvalid1_d = port_q;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      port_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_q    <= 1'b1;             // port 0 wins the first tie
`endif
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

  // Strobes are masked by RESET so an access interrupted in ACCESS cannot
  // commit at the reset edge: the memory samples RAM_WEN on that same edge.
  assign in_access = (state_q == S_ACCESS) && !RESET;

  assign GNT0     = in_access && !port_q;
  assign GNT1     = in_access &&  port_q;
  assign RAM_WEN  = in_access && we_q;
  assign RAM_EX   = in_access && we_q;
  assign BUSY     = (state_q != S_IDLE);
  assign RAM_ADDR = addr_q;
  assign RAM_IN   = wdata_q;
  assign RDATA    = rdata_q;
  assign RVALID0  = rvalid0_q;
  assign RVALID1  = rvalid1_q;

endmodule
